// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock manager: holds the PLL in reset, qualifies lock, then releases
// per-channel resets in a staggered order. Lock loss and relock requests restart the sequence.
module pll_lock_sequencer #(
  parameter int N_CLK        = 3,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int LOCK_STABLE  = 1024,
  parameter int STAGGER      = 8,
  parameter int CNT_W        = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic [N_CLK-1:0] chan_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] relock_count,
  output logic             timeout_err
);

  localparam int REL_LAST = STAGGER * (N_CLK - 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int LW = $clog2(REL_LAST + 2);

  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] ST_LAST  = SW'(LOCK_STABLE - 1);
  localparam logic [LW-1:0] RL_LAST  = LW'(REL_LAST);

  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

  state_t        state;
  logic          lk_s1, lk;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] st_cnt;
  logic [LW-1:0] rel_cnt;
  logic          fault, timeout_hit;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_s1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      lk_s1 <= pll_locked;
      lk    <= lk_s1;
    end
  end

  // relock_req is ignored while the PLL is already being reset
  always_comb begin
    timeout_hit = (state == WAIT_LOCK) && !lk && (to_cnt == TO_LAST);
    fault       = (state != RESET_PLL) &&
                  (relock_req || (!lk && (state == RELEASE || state == RUN)));
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RESET_PLL;
      pll_rst      <= 1'b1;
      chan_rst_n   <= '0;
      ready        <= 1'b0;
      relock_count <= '0;
      timeout_err  <= 1'b0;
      rst_cnt      <= '0;
      to_cnt       <= '0;
      st_cnt       <= '0;
      rel_cnt      <= '0;
    end else if (fault) begin
      state      <= RESET_PLL;
      pll_rst    <= 1'b1;
      chan_rst_n <= '0;
      ready      <= 1'b0;
      rst_cnt    <= '0;
      to_cnt     <= '0;
      st_cnt     <= '0;
      rel_cnt    <= '0;
      if (relock_count != '1) relock_count <= relock_count + 1'b1;
      if (timeout_hit) timeout_err <= 1'b1;
    end else begin
      case (state)
        RESET_PLL: begin
          if (rst_cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            pll_rst <= 1'b0;
            rst_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state  <= STABLE;
            st_cnt <= SW'(1);
          end else if (timeout_hit) begin
            state       <= RESET_PLL;
            pll_rst     <= 1'b1;
            timeout_err <= 1'b1;
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        // to_cnt is kept across glitches so the total time waiting for lock stays bounded
        STABLE: begin
          if (!lk) begin
            state <= WAIT_LOCK;
          end else if (st_cnt >= ST_LAST) begin
            state         <= RELEASE;
            chan_rst_n[0] <= 1'b1;
            st_cnt        <= '0;
          end else begin
            st_cnt <= st_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (rel_cnt == RL_LAST) begin
            state   <= RUN;
            ready   <= 1'b1;
            rel_cnt <= '0;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
            for (int i = 1; i < N_CLK; i++)
              if (int'(rel_cnt) + 1 == STAGGER * i) chan_rst_n[i] <= 1'b1;
          end
        end
        RUN: ;
        default: begin
          state   <= RESET_PLL;
          pll_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Parametrised reset/lock manager that sits beside a multi-output PLL instance in sys/pll.
- Drives the PLL reset and supervises its lock signal, including retry on lock timeout.
- Releases per-output-domain resets in a staggered order once lock is stable.
- Handles lock loss and software relock requests, and exposes status (ready, relock count, timeout flag) to the framework.

Parameters:
- N_CLK, 3, number of PLL output channels sequenced (1..18).
- RST_CYCLES, 16, cycles pll_rst is held high per PLL reset.
- LOCK_TIMEOUT, 1000000, max cycles waiting for lock before retry.
- LOCK_STABLE, 1024, consecutive synchronised-locked cycles required before release.
- STAGGER, 8, cycles between successive channel reset releases (>=1).
- CNT_W, 8, relock counter width.

Ports:
- refclk  input  1  reference clock; all logic in this domain.
- rst_n  input  1  asynchronous active-low reset.
- pll_locked  input  1  PLL lock, asynchronous to refclk.
- relock_req  input  1  single-cycle request to force a full PLL reset.
- pll_rst  output  1  active-high reset to the PLL.
- chan_rst_n  output  N_CLK  per-channel active-low reset enables. Each downstream domain re-synchronises its own bit.
- ready  output  1  all channels released, PLL locked.
- relock_count  output  CNT_W  number of lock losses plus relock requests since rst_n; saturates at all-ones.
- timeout_err  output  1  sticky: a lock timeout occurred since rst_n.

Behaviour:
- Reset values (rst_n low):
  - state RESET_PLL, pll_rst=1, chan_rst_n=0, ready=0, relock_count=0, timeout_err=0.
  - All counters 0.
  - Synchroniser flops 0.
- pll_locked passes through a 2-flop synchroniser; "lk" below is the synchronised value (2-cycle latency).
- RESET_PLL:
  - pll_rst=1, chan_rst_n=0, ready=0.
  - Stays exactly RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0; timeout counter increments each cycle.
  - lk=1 -> STABLE, stable counter loaded with 1.
  - Counter reaches LOCK_TIMEOUT with lk=0 -> timeout_err set, then RESET_PLL. relock_count is not incremented on timeout.
- STABLE:
  - Stable counter increments while lk=1.
  - lk=0 -> WAIT_LOCK; the timeout counter is NOT cleared, so the total wait is bounded.
  - Counter reaches LOCK_STABLE -> RELEASE.
- RELEASE:
  - chan_rst_n[0] goes high on the first RELEASE cycle.
  - chan_rst_n[i] goes high STAGGER*i cycles after chan_rst_n[0].
  - One cycle after chan_rst_n[N_CLK-1] goes high -> RUN.
  - Bits once released stay high until a fault.
- RUN:
  - ready=1; stays in RUN while lk=1 and no relock_req.
- Fault (lk=0 in RELEASE or RUN, or relock_req in any state except RESET_PLL):
  - Next cycle: state RESET_PLL, pll_rst=1, chan_rst_n all 0, ready=0.
  - relock_count increments by 1 (saturating).
  - All counters cleared.
- relock_req during RESET_PLL is ignored: no count increment and no restart of RST_CYCLES.
- Simultaneous relock_req and lk=0: counted once.
- Simultaneous timeout and relock_req in WAIT_LOCK: relock_req wins, so relock_count increments; timeout_err is also set.
- N_CLK=1: RELEASE lasts 1 cycle.
- Counter widths sized with $clog2 of their respective limit + 1; no wrap is possible.
- Outputs are registered.
- rst_n assertion mid-sequence asynchronously forces the reset values immediately.

Test Plan (params N_CLK=3, RST_CYCLES=4, LOCK_TIMEOUT=50, LOCK_STABLE=8, STAGGER=2, CNT_W=4):
- Normal bring-up:
  - Stimulus: release rst_n; pll_locked=1 from cycle 10.
  - Response: pll_rst high for cycles 0-3.
  - Response: chan_rst_n goes 001, then 011 two cycles later, then 111 two cycles after that.
  - Response: ready=1 one cycle after 111; relock_count=0.
- Lock glitch in STABLE:
  - Stimulus: pll_locked drops 1 cycle after 5 stable cycles.
  - Response: stable count restarts; release is delayed by ≥8 further lk-high cycles; no pll_rst pulse; relock_count=0.
- Lock timeout:
  - Stimulus: pll_locked held 0.
  - Response: after 50 WAIT_LOCK cycles, timeout_err=1 (stays 1) and pll_rst pulses 4 cycles.
  - Response: sequence repeats every 54 cycles.
- Lock loss in RUN:
  - Stimulus: drop pll_locked in RUN.
  - Response: 3 cycles later (2 synchroniser + 1 register), chan_rst_n=000, ready=0, pll_rst=1, relock_count=1.
  - Response: full re-sequence once lock returns.
- relock_req:
  - Stimulus: relock_req in RUN.
  - Response: relock_count=1 and a 4-cycle pll_rst.
  - Stimulus: second relock_req during RESET_PLL.
  - Response: ignored; count stays 1.
- Saturation and reset mid-operation:
  - Stimulus: 20 relock_reqs.
  - Response: relock_count=15.
  - Stimulus: assert rst_n during RELEASE.
  - Response: outputs return to reset values in the same cycle, with no clock edge needed.
